// File: rtl/rc4_key_search_ctrl.sv
// ---------------------------------------------------------------------------
// rc4_key_search_ctrl
//
// Brute-force RC4 key search sequencer. For each candidate key it runs the
// S-init, KSA-shuffle and decrypt engines one after another, hands the s_mem
// port to each engine in turn, and then reads the decrypted message back out
// of d_mem. A key is accepted when every byte is a lowercase letter or a
// space. Otherwise the next key is tried, until KEY_MAX is exhausted.
//
// Ports
//   clk                       single clock, all state changes on posedge
//   reset                     synchronous, active-high
//   start                     level request to begin a search (ignored while busy)
//   init_start/shuf_start/dec_start  one-cycle engine start pulses
//   init_done/shuf_done/dec_done     one-cycle engine completion pulses
//   s_grant[1:0]              s_mem owner: 00 none, 01 init, 10 shuffle, 11 decrypt
//   d_sel                     d_mem owner: 0 decrypt engine, 1 checker
//   key[23:0]                 current candidate key
//   d_addr[7:0]               checker read address into d_mem
//   d_q[7:0]                  d_mem read data, valid 2 cycles after d_addr
//   busy/done/found/fail      search status
// ---------------------------------------------------------------------------
module rc4_key_search_ctrl #(
   parameter logic [23:0] KEY_MAX = 24'h3FFFFF,
   parameter int          MSG_LEN = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        init_start,
   output logic        shuf_start,
   output logic        dec_start,
   input  logic        init_done,
   input  logic        shuf_done,
   input  logic        dec_done,
   output logic [1:0]  s_grant,
   output logic        d_sel,
   output logic [23:0] key,
   output logic [7:0]  d_addr,
   input  logic [7:0]  d_q,
   output logic        busy,
   output logic        done,
   output logic        found,
   output logic        fail
);

   localparam logic [7:0] LAST_IDX = 8'(MSG_LEN - 1);

   typedef enum logic [3:0] {
      IDLE, INIT, W_INIT, SHUF, W_SHUF, DEC, W_DEC,
      CHK_ADDR, CHK_WAIT, CHK_DATA, NEXT_KEY, FOUND, FAIL
   } state_t;

   state_t      state_q, state_d;
   logic [23:0] key_q, key_d;
   logic [7:0]  k_q, k_d;
   logic        done_q, done_d;
   logic        found_q, found_d;
   logic        fail_q, fail_d;

   logic        byte_ok;

   // Accepted plaintext alphabet: 'a'..'z' or ' '.
   assign byte_ok = ((d_q >= 8'd97) && (d_q <= 8'd122)) || (d_q == 8'd32);

   // NOTE: every register here, including the status flags, is cleared by the
   // synchronous reset so the block comes out of reset in a known, idle state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         key_q   <= '0;
         k_q     <= '0;
         done_q  <= 1'b0;
         found_q <= 1'b0;
         fail_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so all registers update together
         // from the values sampled at this edge.
         state_q <= state_d;
         key_q   <= key_d;
         k_q     <= k_d;
         done_q  <= done_d;
         found_q <= found_d;
         fail_q  <= fail_d;
      end
   end

   always_comb begin
      // NOTE: every output and next-state value gets a default first so no
      // path through the case statement can infer a latch.
      state_d    = state_q;
      key_d      = key_q;
      k_d        = k_q;
      done_d     = done_q;
      found_d    = found_q;
      fail_d     = fail_q;
      init_start = 1'b0;
      shuf_start = 1'b0;
      dec_start  = 1'b0;
      s_grant    = 2'b00;
      d_sel      = 1'b0;
      d_addr     = 8'd0;
      busy       = 1'b1;

      case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_d = INIT;
               key_d   = '0;
               k_d     = '0;
               done_d  = 1'b0;
               found_d = 1'b0;
               fail_d  = 1'b0;
            end
         end

         INIT: begin
            init_start = 1'b1;
            s_grant    = 2'b01;
            state_d    = W_INIT;
         end
         W_INIT: begin
            s_grant = 2'b01;
            if (init_done) state_d = SHUF;
         end

         SHUF: begin
            shuf_start = 1'b1;
            s_grant    = 2'b10;
            state_d    = W_SHUF;
         end
         W_SHUF: begin
            s_grant = 2'b10;
            if (shuf_done) state_d = DEC;
         end

         DEC: begin
            dec_start = 1'b1;
            s_grant   = 2'b11;
            state_d   = W_DEC;
         end
         W_DEC: begin
            s_grant = 2'b11;
            if (dec_done) begin
               state_d = CHK_ADDR;
               k_d     = '0;
            end
         end

         // Address is held for three cycles so the 2-cycle d_mem latency
         // lands the byte in CHK_DATA.
         CHK_ADDR: begin
            d_sel   = 1'b1;
            d_addr  = k_q;
            state_d = CHK_WAIT;
         end
         CHK_WAIT: begin
            d_sel   = 1'b1;
            d_addr  = k_q;
            state_d = CHK_DATA;
         end
         CHK_DATA: begin
            d_sel  = 1'b1;
            d_addr = k_q;
            if (!byte_ok) begin
               state_d = NEXT_KEY;
            end else if (k_q == LAST_IDX) begin
               state_d = FOUND;
               found_d = 1'b1;
               done_d  = 1'b1;
            end else begin
               k_d     = k_q + 8'd1;
               state_d = CHK_ADDR;
            end
         end

         // Every new key needs a fresh S table, so loop back to INIT.
         NEXT_KEY: begin
            if (key_q == KEY_MAX) begin
               state_d = FAIL;
               fail_d  = 1'b1;
               done_d  = 1'b1;
            end else begin
               key_d   = key_q + 24'd1;
               state_d = INIT;
            end
         end

         // The winning / last key is visible for this one cycle; key returns
         // to zero in IDLE while the status flags are held.
         FOUND: begin
            busy    = 1'b0;
            key_d   = '0;
            state_d = IDLE;
         end
         FAIL: begin
            busy    = 1'b0;
            key_d   = '0;
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   assign key   = key_q;
   assign done  = done_q;
   assign found = found_q;
   assign fail  = fail_q;

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rc4_key_search_ctrl
//
// Directed bench for rc4_key_search_ctrl (KEY_MAX=3, MSG_LEN=32). Engine
// responders answer each start pulse after a fixed latency; d_mem is a
// 2-cycle-latency model whose contents depend on the scenario and the key.
// Each search pushes its expected outcome to a scoreboard queue, popped when
// the DUT reports done.
// ---------------------------------------------------------------------------
module tb_rc4_key_search_ctrl;

   localparam logic [23:0] KEY_MAX_TB = 24'd3;
   localparam int          MSG_LEN_TB = 32;
   localparam int          ENG_LAT    = 3;
   localparam int          BUDGET     = 5000;

   logic        clk;
   logic        reset;
   logic        start;
   logic        init_start, shuf_start, dec_start;
   logic        init_done, shuf_done, dec_done;
   logic [1:0]  s_grant;
   logic        d_sel;
   logic [23:0] key;
   logic [7:0]  d_addr;
   logic [7:0]  d_q;
   logic        busy, done, found, fail;

   rc4_key_search_ctrl #(
      .KEY_MAX (KEY_MAX_TB),
      .MSG_LEN (MSG_LEN_TB)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .init_start (init_start),
      .shuf_start (shuf_start),
      .dec_start  (dec_start),
      .init_done  (init_done),
      .shuf_done  (shuf_done),
      .dec_done   (dec_done),
      .s_grant    (s_grant),
      .d_sel      (d_sel),
      .key        (key),
      .d_addr     (d_addr),
      .d_q        (d_q),
      .busy       (busy),
      .done       (done),
      .found      (found),
      .fail       (fail)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        found;
      logic        fail;
      logic [23:0] key;
      int          keys;
   } exp_t;

   exp_t sb_q[$];

   int vectors     = 0;
   int miscompares = 0;

   int scenario    = 1;
   int dec_lat     = ENG_LAT;
   bit stray_en    = 1'b0;
   bit stray_pend  = 1'b0;
   int n_init      = 0;
   int n_shuf      = 0;
   int n_dec       = 0;
   int n_multi     = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // d_mem contents written by the decrypt engine for a given key.
   function automatic logic [7:0] mem_byte(input int sc, input logic [23:0] k,
                                           input logic [7:0] a);
      case (sc)
         1: return 8'h61;
         2: if (k == 24'd0) return (a == 8'd0) ? 8'h00 : 8'h61;
            else return 8'h20;
         3: return 8'h7B;
         4: if (k == 24'd0) return (a == 8'd31) ? 8'h60 : 8'h61;
            else return (a == 8'd31) ? 8'h7A : 8'h20;
         default: return 8'h61;
      endcase
   endfunction

   // Engine responders and d_mem model, all driven at the falling edge.
   initial begin : responder
      int ic, sc, dc;
      logic [7:0] pipe;
      ic = 0; sc = 0; dc = 0; pipe = 8'h00;
      init_done = 1'b0; shuf_done = 1'b0; dec_done = 1'b0; d_q = 8'h00;
      forever begin
         @(negedge clk);
         init_done = 1'b0;
         shuf_done = 1'b0;
         dec_done  = 1'b0;
         if (stray_pend) begin
            stray_pend = 1'b0;
            check("stray_grant_held", s_grant, 2'b11);
            check("stray_no_init",    init_start, 1'b0);
         end
         if (reset) begin
            ic = 0; sc = 0; dc = 0;
         end else begin
            if (ic > 0) begin ic--; if (ic == 0) init_done = 1'b1; end
            if (sc > 0) begin sc--; if (sc == 0) shuf_done = 1'b1; end
            if (dc > 0) begin
               dc--;
               if (dc == 0) dec_done = 1'b1;
               else if (stray_en && dc == 2) begin
                  init_done  = 1'b1;
                  stray_pend = 1'b1;
               end
            end
            if (init_start) begin ic = ENG_LAT; n_init++; end
            if (shuf_start) begin sc = ENG_LAT; n_shuf++; end
            if (dec_start)  begin dc = dec_lat; n_dec++;  end
            if ((32'(init_start) + 32'(shuf_start) + 32'(dec_start)) > 1) n_multi++;
         end
         d_q  = pipe;
         pipe = mem_byte(scenario, key, d_addr);
      end
   end

   task automatic run_search(input int sc, input logic exp_found, input logic exp_fail,
                             input logic [23:0] exp_key, input int exp_keys, input bit hold);
      exp_t e, got;
      bit   seen;
      scenario = sc;
      n_init = 0; n_shuf = 0; n_dec = 0;
      e.found = exp_found; e.fail = exp_fail; e.key = exp_key; e.keys = exp_keys;
      sb_q.push_back(e);
      @(negedge clk);
      start = 1'b1;
      if (!hold) begin
         @(negedge clk);
         start = 1'b0;
      end
      seen = 1'b0;
      for (int i = 0; i < BUDGET; i++) begin
         @(negedge clk);
         if (done === 1'b1 && busy === 1'b0) begin
            seen = 1'b1;
            break;
         end
      end
      start = 1'b0;
      check($sformatf("s%0d_completed", sc), seen, 1'b1);
      if (seen) begin
         if (sb_q.size() == 0) begin
            check($sformatf("s%0d_sb_empty", sc), 0, 1);
         end else begin
            got = sb_q.pop_front();
            check($sformatf("s%0d_found", sc), found, got.found);
            check($sformatf("s%0d_fail",  sc), fail,  got.fail);
            check($sformatf("s%0d_key",   sc), key,   got.key);
            check($sformatf("s%0d_inits", sc), n_init, got.keys);
            check($sformatf("s%0d_shufs", sc), n_shuf, got.keys);
            check($sformatf("s%0d_decs",  sc), n_dec,  got.keys);
         end
         @(negedge clk);
         check($sformatf("s%0d_idle_key",  sc), key,  24'd0);
         check($sformatf("s%0d_idle_busy", sc), busy, 1'b0);
         check($sformatf("s%0d_idle_done", sc), done, 1'b1);
         check($sformatf("s%0d_idle_found", sc), found, exp_found);
      end
   endtask

   initial begin : stimulus
      bit seen;
      reset = 1'b1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_state_flags", {busy, done, found, fail}, 4'b0000);
      check("rst_starts", {init_start, shuf_start, dec_start}, 3'b000);
      check("rst_grant", {s_grant, d_sel}, 3'b000);
      check("rst_key", key, 24'd0);
      check("rst_daddr", d_addr, 8'd0);
      reset = 1'b0;
      @(negedge clk);

      // All bytes 'a': accepted on the first key.
      run_search(1, 1'b1, 1'b0, 24'd0, 1, 1'b0);
      // Key 0 has a NUL at byte 0; key 1 is all spaces.
      run_search(2, 1'b1, 1'b0, 24'd1, 2, 1'b0);
      // '{' everywhere: every key rejected, search fails at KEY_MAX.
      run_search(3, 1'b0, 1'b1, 24'd3, 4, 1'b0);
      // Key 0 rejected only at the last byte ('`'); key 1 ends in 'z'.
      run_search(4, 1'b1, 1'b0, 24'd1, 2, 1'b0);

      // Reset while waiting on the shuffle engine.
      scenario = 1;
      n_init = 0; n_shuf = 0; n_dec = 0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (s_grant === 2'b10 && shuf_start === 1'b0) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("s5_reached_wshuf", seen, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      check("s5_rst_flags", {busy, done, found, fail}, 4'b0000);
      check("s5_rst_starts", {init_start, shuf_start, dec_start}, 3'b000);
      check("s5_rst_grant", {s_grant, d_sel}, 3'b000);
      check("s5_rst_key_addr", {key, d_addr}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (30) @(negedge clk);
      check("s5_no_dec_start", n_dec, 0);
      check("s5_still_idle", busy, 1'b0);

      // start held throughout, stray init_done during the decrypt wait.
      dec_lat  = 6;
      stray_en = 1'b1;
      run_search(6, 1'b1, 1'b0, 24'd0, 1, 1'b1);
      stray_en = 1'b0;
      repeat (3) @(negedge clk);
      check("s6_no_restart", busy, 1'b0);
      check("s6_init_count", n_init, 1);

      check("single_start_pulse", n_multi, 0);
      check("scoreboard_drained", sb_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
